bus_ack_responder: RTL

//  Target-side responder for the dual-channel req/ack bus: watches req1/req2,

---
 rtl/bus_ack_responder.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/bus_ack_responder.sv
// Target-side responder for the dual-channel req/ack bus: arbitrates req1/req2, owns bus_select,
// and returns a registered ack ACK_DLY cycles after each request. Define RESP_SVA_EN to embed protocol assertions.
module bus_ack_responder #(
  parameter int ACK_DLY = 2,
  parameter int ACK_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req1,
  input  logic       req2,
  output logic       ack1,
  output logic       ack2,
  output logic [1:0] bus_select,
  output logic       bus_switch,
  output logic       busy
);

  typedef enum logic [1:0] {S_IDLE, S_SWITCH, S_WAIT, S_ACK} state_t;

  localparam logic [1:0] DLY_LD  = 2'(ACK_DLY - 1);
  localparam logic [1:0] LEN_LD  = 2'(ACK_LEN - 1);
  localparam logic [1:0] SEL_CH1 = 2'b01;
  localparam logic [1:0] SEL_CH2 = 2'b10;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [1:0] r_cnt;
  logic [1:0] w_cnt_nxt;
  logic       r_grant;      // channel being served: 0 = ch1, 1 = ch2
  logic       w_grant_nxt;
  logic       r_last;       // last channel acked: 0 = ch1, 1 = ch2
  logic [1:0] r_sel;
  logic [1:0] w_sel_nxt;
  logic       r_req1_q;
  logic       r_req2_q;
  logic       r_pend1;
  logic       r_pend2;
  logic       r_ack1;
  logic       r_ack2;
  logic       r_switch;
  logic       w_rise1;
  logic       w_rise2;
  logic       w_cand1;
  logic       w_cand2;
  logic       w_win2;
  logic [1:0] w_win_sel;
  logic       w_clr;

  assign w_rise1   = req1 & ~r_req1_q;
  assign w_rise2   = req2 & ~r_req2_q;
  assign w_cand1   = r_pend1 | w_rise1;
  assign w_cand2   = r_pend2 | w_rise2;
  // With both channels asking, the one not served last goes first.
  assign w_win2    = w_cand2 & (~w_cand1 | ~r_last);
  assign w_win_sel = w_win2 ? SEL_CH2 : SEL_CH1;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    w_sel_nxt   = r_sel;
    w_clr       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_cand1 | w_cand2) begin
          w_grant_nxt = w_win2;
          w_cnt_nxt   = DLY_LD;
          w_state_nxt = (w_win_sel != r_sel) ? S_SWITCH : S_WAIT;
        end
      end
      S_SWITCH: begin
        w_sel_nxt   = r_grant ? SEL_CH2 : SEL_CH1;
        w_cnt_nxt   = DLY_LD;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (r_cnt == 2'd0) begin
          w_cnt_nxt   = LEN_LD;
          w_clr       = 1'b1;
          w_state_nxt = S_ACK;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      S_ACK: begin
        if (r_cnt == 2'd0) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - 2'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 2'd0;
      r_grant  <= 1'b0;
      r_last   <= 1'b1;
      r_sel    <= 2'b00;
      r_ack1   <= 1'b0;
      r_ack2   <= 1'b0;
      r_switch <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_grant  <= w_grant_nxt;
      r_sel    <= w_sel_nxt;
      r_ack1   <= (w_state_nxt == S_ACK) & ~w_grant_nxt;
      r_ack2   <= (w_state_nxt == S_ACK) & w_grant_nxt;
      r_switch <= (w_state_nxt == S_SWITCH);
      if (w_clr) r_last <= r_grant;
    end
  end

  // A rise landing on the clearing cycle keeps the request pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req1_q <= 1'b0;
      r_req2_q <= 1'b0;
      r_pend1  <= 1'b0;
      r_pend2  <= 1'b0;
    end else begin
      r_req1_q <= req1;
      r_req2_q <= req2;
      r_pend1  <= w_rise1 | (r_pend1 & ~(w_clr & ~r_grant));
      r_pend2  <= w_rise2 | (r_pend2 & ~(w_clr & r_grant));
    end
  end

  assign ack1       = r_ack1;
  assign ack2       = r_ack2;
  assign bus_select = r_sel;
  assign bus_switch = r_switch;
  assign busy       = (r_state != S_IDLE);

`ifdef RESP_SVA_EN
  a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0({r_ack1, r_ack2}));
  a_sw_no_ack:  assert property (@(posedge clk) disable iff (rst) r_switch |-> !(r_ack1 | r_ack2));
  a_ack1_sel:   assert property (@(posedge clk) disable iff (rst) r_ack1 |-> (r_sel == SEL_CH1));
  a_ack2_sel:   assert property (@(posedge clk) disable iff (rst) r_ack2 |-> (r_sel == SEL_CH2));
  // Latency bound holds for isolated requests; a same-edge rival is excluded.
  a_lat1: assert property (@(posedge clk) disable iff (rst)
    ($rose(req1) && !(r_pend2 || w_rise2) && !busy) |-> ##[1:5] r_ack1);
  a_lat2: assert property (@(posedge clk) disable iff (rst)
    ($rose(req2) && !(r_pend1 || w_rise1) && !busy) |-> ##[1:5] r_ack2);
`endif

endmodule
